mul_cond_seq: RTL and testbench

Parametrised execute-stage sequencer for the multicycle ARM core. It owns the NZCV flag register and evaluates the ARM condition field, then gates register, memory and PC writes. It adds a counted wait for an iterative multiplier of configurable latency and a one- or two-slot writeback sequence (MUL: RdLo only; long multiply: RdLo then RdHi). It sits between the main decoder and the datapath, in place of the old single-cycle condition logic.

---
 rtl/mul_cond_seq_pkg.sv | 34 +++
 rtl/mul_cond_seq_if.sv | 33 +++
 rtl/mul_cond_seq_cond_eval.sv | 41 ++++
 rtl/mul_cond_seq.sv | 142 ++++++++++++++
 tb/tb_mul_cond_seq.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_cond_seq_pkg.sv
// Shared definitions for the execute-stage sequencer and the condition evaluator:
// ARM condition codes, NZCV bit positions and the sequencer state encoding.
package mul_cond_seq_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_WB_LO    = 2'd2,
    ST_WB_HI    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mul_cond_seq_if.sv
// Decoder-to-sequencer bundle: decoded controls and ALU flags in, gated write
// enables, multiplier launch and status back out.
interface mul_cond_seq_if;

  logic       issue;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       is_mul;
  logic       long_mul;

  logic       mul_start;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       wb_hi;
  logic       busy;
  logic [3:0] flags;

  modport master (
    output issue, cond, alu_flags, flag_w, pcs, reg_w, mem_w, is_mul, long_mul,
    input  mul_start, pc_write, reg_write, mem_write, wb_hi, busy, flags
  );

  modport slave (
    input  issue, cond, alu_flags, flag_w, pcs, reg_w, mem_w, is_mul, long_mul,
    output mul_start, pc_write, reg_write, mem_write, wb_hi, busy, flags
  );

endinterface

// File: rtl/mul_cond_seq_cond_eval.sv
// ARM condition-field evaluator: purely combinational, shared with the branch unit.
module cond_eval
  import mul_cond_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field against the current NZCV register.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mul_cond_seq.sv
// Execute-stage sequencer: owns NZCV, gates writes by condition, waits out the
// iterative multiplier and then steps through one or two writeback slots.
module mul_cond_seq
  import mul_cond_seq_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  mul_cond_seq_if.slave  bus
);

  if (MUL_LAT < 1 || MUL_LAT > 15 || CNT_W != 4) begin : g_param_check
    $error("mul_cond_seq: MUL_LAT must be within 1..15 and CNT_W must be 4");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       flags_q;
  logic             cap_long;
  logic [1:0]       cap_fw;
  logic             busy_q;

  logic             cond_ex;
  logic             capture;
  logic             upd_nz;
  logic             upd_cv;
  logic             mul_start_c;
  logic             pc_write_c;
  logic             reg_write_c;
  logic             mem_write_c;
  logic             wb_hi_c;

  cond_eval u_cond_eval (
    .cond    (bus.cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Next-state, gated write enables and flag-update strobes for the current state.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    upd_nz      = 1'b0;
    upd_cv      = 1'b0;
    mul_start_c = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    wb_hi_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.issue) begin
          if (!bus.is_mul) begin
            pc_write_c  = bus.pcs & cond_ex;
            reg_write_c = bus.reg_w & cond_ex;
            mem_write_c = bus.mem_w & cond_ex;
            upd_nz      = cond_ex & bus.flag_w[1];
            upd_cv      = cond_ex & bus.flag_w[0];
          end else if (cond_ex) begin
            mul_start_c = 1'b1;
            capture     = 1'b1;
            state_nxt   = ST_MUL_WAIT;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_WB_LO;
        end
      end
      ST_WB_LO: begin
        reg_write_c = 1'b1;
        if (cap_long) begin
          state_nxt = ST_WB_HI;
        end else begin
          state_nxt = ST_IDLE;
          upd_nz    = cap_fw[1];
          upd_cv    = cap_fw[0];
        end
      end
      ST_WB_HI: begin
        reg_write_c = 1'b1;
        wb_hi_c     = 1'b1;
        state_nxt   = ST_IDLE;
        upd_nz      = cap_fw[1];
        upd_cv      = cap_fw[0];
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      mul_start_c = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      mem_write_c = 1'b0;
      wb_hi_c     = 1'b0;
    end
  end

  // State, wait counter, captured multiply controls, busy and the NZCV register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      flags_q  <= 4'b0000;
      cap_long <= 1'b0;
      cap_fw   <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      if (capture) begin
        cap_long <= bus.long_mul;
        cap_fw   <= bus.flag_w;
        cnt      <= CNT_LOAD;
      end else if (state == ST_MUL_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (upd_nz) begin
        flags_q[FLAG_N] <= bus.alu_flags[FLAG_N];
        flags_q[FLAG_Z] <= bus.alu_flags[FLAG_Z];
      end
      if (upd_cv) begin
        flags_q[FLAG_C] <= bus.alu_flags[FLAG_C];
        flags_q[FLAG_V] <= bus.alu_flags[FLAG_V];
      end
    end
  end

  assign bus.mul_start = mul_start_c;
  assign bus.pc_write  = pc_write_c;
  assign bus.reg_write = reg_write_c;
  assign bus.mem_write = mem_write_c;
  assign bus.wb_hi     = wb_hi_c;
  assign bus.busy      = busy_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_mul_cond_seq.sv
// Bench for mul_cond_seq: one instance with a 4-cycle multiplier and one with a
// 1-cycle multiplier, table vectors for single-cycle ops, scoreboarded multiplies.
module tb_mul_cond_seq;

  typedef struct {
    logic       issue;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       is_mul;
    logic       long_mul;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [3:0] exp_wr;
    logic [3:0] exp_flags;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic       mul_start;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       wb_hi;
    logic       busy;
    logic [3:0] flags;
  } outs_t;

  typedef struct {
    int   cyc;
    logic hi;
  } wb_exp_t;

  logic clock;
  logic reset4;
  logic reset1;
  int   checks;
  int   failures;
  wb_exp_t sbq[$];

  mul_cond_seq_if bus4 ();
  mul_cond_seq_if bus1 ();

  mul_cond_seq #(.MUL_LAT(4), .CNT_W(4)) dut4 (
    .clk   (clock),
    .reset (reset4),
    .bus   (bus4)
  );

  mul_cond_seq #(.MUL_LAT(1), .CNT_W(4)) dut1 (
    .clk   (clock),
    .reset (reset1),
    .bus   (bus1)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, required summary before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mkStim(input logic [3:0] cond, input logic [3:0] alu,
                                   input logic [1:0] fw, input logic pcs,
                                   input logic reg_w, input logic mem_w,
                                   input logic is_mul, input logic long_mul);
    stim_t s;
    s.issue    = 1'b1;
    s.cond     = cond;
    s.alu      = alu;
    s.fw       = fw;
    s.pcs      = pcs;
    s.reg_w    = reg_w;
    s.mem_w    = mem_w;
    s.is_mul   = is_mul;
    s.long_mul = long_mul;
    return s;
  endfunction

  function automatic stim_t idleStim(input logic [3:0] alu);
    stim_t s;
    s = mkStim(4'hE, alu, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s.issue = 1'b0;
    return s;
  endfunction

  task automatic applyStimulus(input int d, input stim_t s);
    if (d == 4) begin
      bus4.issue = s.issue; bus4.cond = s.cond; bus4.alu_flags = s.alu;
      bus4.flag_w = s.fw; bus4.pcs = s.pcs; bus4.reg_w = s.reg_w;
      bus4.mem_w = s.mem_w; bus4.is_mul = s.is_mul; bus4.long_mul = s.long_mul;
    end else begin
      bus1.issue = s.issue; bus1.cond = s.cond; bus1.alu_flags = s.alu;
      bus1.flag_w = s.fw; bus1.pcs = s.pcs; bus1.reg_w = s.reg_w;
      bus1.mem_w = s.mem_w; bus1.is_mul = s.is_mul; bus1.long_mul = s.long_mul;
    end
  endtask

  function automatic outs_t readOutputs(input int d);
    outs_t o;
    if (d == 4) begin
      o.mul_start = bus4.mul_start; o.pc_write = bus4.pc_write;
      o.reg_write = bus4.reg_write; o.mem_write = bus4.mem_write;
      o.wb_hi = bus4.wb_hi; o.busy = bus4.busy; o.flags = bus4.flags;
    end else begin
      o.mul_start = bus1.mul_start; o.pc_write = bus1.pc_write;
      o.reg_write = bus1.reg_write; o.mem_write = bus1.mem_write;
      o.wb_hi = bus1.wb_hi; o.busy = bus1.busy; o.flags = bus1.flags;
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] packWrites(input outs_t o);
    return 32'({o.mul_start, o.pc_write, o.reg_write, o.mem_write, o.wb_hi});
  endfunction

  // Pops the next expected writeback whenever the DUT writes the register file.
  task automatic scoreboardStep(input int d, input int k);
    outs_t   o;
    wb_exp_t e;
    o = readOutputs(d);
    if (o.reg_write) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected writeback: reg_write=1 at cycle %0d, expected none", k);
      end else begin
        e = sbq.pop_front();
        checkOutput($sformatf("wb cycle dut%0d", d), 32'(k), 32'(e.cyc));
        checkOutput($sformatf("wb_hi dut%0d", d), 32'(o.wb_hi), 32'(e.hi));
      end
    end
  endtask

  vec_t  tbl[15];
  outs_t o;

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = '{mkStim(4'hE, 4'b0100, 2'b11, 0, 1, 0, 0, 0), 4'b0010, 4'b0100, 1'b0};
    tbl[1]  = '{mkStim(4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 0), 4'b0100, 4'b0100, 1'b0};
    tbl[2]  = '{mkStim(4'h1, 4'b1111, 2'b11, 1, 1, 1, 0, 0), 4'b0000, 4'b0100, 1'b0};
    tbl[3]  = '{mkStim(4'hE, 4'b0011, 2'b01, 0, 1, 0, 0, 0), 4'b0010, 4'b0111, 1'b0};
    tbl[4]  = '{mkStim(4'h8, 4'b0000, 2'b11, 0, 0, 1, 0, 0), 4'b0000, 4'b0111, 1'b0};
    tbl[5]  = '{mkStim(4'h9, 4'b1000, 2'b10, 0, 0, 1, 0, 0), 4'b0001, 4'b1011, 1'b0};
    tbl[6]  = '{mkStim(4'hA, 4'b0000, 2'b00, 1, 0, 0, 0, 0), 4'b0100, 4'b1011, 1'b0};
    tbl[7]  = '{mkStim(4'hB, 4'b0000, 2'b11, 0, 1, 0, 0, 0), 4'b0000, 4'b1011, 1'b0};
    tbl[8]  = '{mkStim(4'hC, 4'b0000, 2'b11, 0, 1, 0, 0, 0), 4'b0010, 4'b0000, 1'b0};
    tbl[9]  = '{mkStim(4'h0, 4'b1111, 2'b11, 1, 1, 1, 0, 0), 4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{mkStim(4'hF, 4'b1111, 2'b11, 1, 1, 1, 0, 0), 4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{mkStim(4'h4, 4'b0000, 2'b00, 0, 1, 0, 0, 0), 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{mkStim(4'h5, 4'b1001, 2'b11, 1, 0, 0, 0, 0), 4'b0100, 4'b1001, 1'b0};
    tbl[13] = '{mkStim(4'h0, 4'b0000, 2'b00, 0, 1, 0, 1, 0), 4'b0000, 4'b1001, 1'b0};
    tbl[14] = '{mkStim(4'hE, 4'b0000, 2'b11, 0, 1, 1, 0, 0), 4'b0011, 4'b0000, 1'b0};

    // Reset with a live instruction on the bus: everything must stay quiet.
    reset4 = 1'b1;
    reset1 = 1'b1;
    applyStimulus(4, mkStim(4'hE, 4'b1111, 2'b11, 1, 1, 1, 1, 1));
    applyStimulus(1, mkStim(4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    o = readOutputs(4);
    checkOutput("reset dut4 writes", packWrites(o), 32'd0);
    checkOutput("reset dut4 flags", 32'(o.flags), 32'd0);
    checkOutput("reset dut4 busy", 32'(o.busy), 32'd0);
    o = readOutputs(1);
    checkOutput("reset dut1 writes", packWrites(o), 32'd0);
    checkOutput("reset dut1 flags", 32'(o.flags), 32'd0);
    reset4 = 1'b0;
    reset1 = 1'b0;
    applyStimulus(4, idleStim(4'b0000));
    applyStimulus(1, idleStim(4'b0000));

    // Single-cycle instructions and a failed conditional multiply on dut4.
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      applyStimulus(4, tbl[i].s);
      #1;
      o = readOutputs(4);
      checkOutput($sformatf("vec%0d writes", i), packWrites(o), 32'({tbl[i].exp_wr, 1'b0}));
      @(posedge clock);
      #1;
      o = readOutputs(4);
      checkOutput($sformatf("vec%0d flags", i), 32'(o.flags), 32'(tbl[i].exp_flags));
      checkOutput($sformatf("vec%0d busy", i), 32'(o.busy), 32'(tbl[i].exp_busy));
    end

    // MUL on the 4-cycle instance, with a stray issue during the wait.
    @(negedge clock);
    applyStimulus(4, mkStim(4'hE, 4'b0000, 2'b00, 0, 1, 0, 1, 0));
    sbq.push_back('{5, 1'b0});
    #1;
    o = readOutputs(4);
    checkOutput("mul issue mul_start", 32'(o.mul_start), 32'd1);
    scoreboardStep(4, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 2) applyStimulus(4, mkStim(4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 0));
      else        applyStimulus(4, idleStim(4'b0000));
      #1;
      o = readOutputs(4);
      checkOutput($sformatf("mul busy k%0d", k), 32'(o.busy), 32'(k <= 5));
      checkOutput($sformatf("mul side writes k%0d", k),
                  32'({o.mul_start, o.pc_write, o.mem_write}), 32'd0);
      scoreboardStep(4, k);
    end
    checkOutput("mul queue drained", 32'(sbq.size()), 32'd0);
    checkOutput("mul ignored issue flags", 32'(readOutputs(4).flags), 32'd0);

    // Reset held two cycles in the middle of the multiply wait.
    @(negedge clock);
    applyStimulus(4, mkStim(4'hE, 4'b1010, 2'b11, 0, 1, 0, 0, 0));
    @(posedge clock);
    #1;
    checkOutput("pre-reset flags", 32'(readOutputs(4).flags), 32'hA);
    @(negedge clock);
    applyStimulus(4, mkStim(4'hE, 4'b0000, 2'b11, 0, 1, 0, 1, 1));
    #1;
    scoreboardStep(4, 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      reset4 = (k == 2 || k == 3);
      applyStimulus(4, idleStim(4'b1111));
      #1;
      o = readOutputs(4);
      if (k == 2) checkOutput("reset mid-wait writes", packWrites(o), 32'd0);
      if (k >= 3) begin
        checkOutput($sformatf("reset flags k%0d", k), 32'(o.flags), 32'd0);
        checkOutput($sformatf("reset busy k%0d", k), 32'(o.busy), 32'd0);
      end
      scoreboardStep(4, k);
    end

    // UMULL on the 1-cycle instance; flags only move after the high writeback.
    @(negedge clock);
    applyStimulus(1, mkStim(4'hE, 4'b1100, 2'b10, 0, 1, 0, 1, 1));
    sbq.push_back('{2, 1'b0});
    sbq.push_back('{3, 1'b1});
    #1;
    o = readOutputs(1);
    checkOutput("umull issue mul_start", 32'(o.mul_start), 32'd1);
    scoreboardStep(1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      applyStimulus(1, idleStim((k == 2) ? 4'b0101 : ((k == 3) ? 4'b1000 : 4'b0000)));
      #1;
      o = readOutputs(1);
      checkOutput($sformatf("umull busy k%0d", k), 32'(o.busy), 32'(k <= 3));
      checkOutput($sformatf("umull flags k%0d", k), 32'(o.flags), (k >= 4) ? 32'h8 : 32'h0);
      scoreboardStep(1, k);
    end
    checkOutput("umull queue drained", 32'(sbq.size()), 32'd0);

    // Reset landing on the WB_LO cycle must suppress that writeback.
    @(negedge clock);
    applyStimulus(1, mkStim(4'hE, 4'b0000, 2'b00, 0, 1, 0, 1, 0));
    #1;
    scoreboardStep(1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      reset1 = (k == 2);
      applyStimulus(1, idleStim(4'b0000));
      #1;
      o = readOutputs(1);
      if (k == 1) checkOutput("wb reset busy k1", 32'(o.busy), 32'd1);
      if (k == 2) checkOutput("wb reset reg_write", 32'(o.reg_write), 32'd0);
      if (k >= 3) begin
        checkOutput($sformatf("wb reset busy k%0d", k), 32'(o.busy), 32'd0);
        checkOutput($sformatf("wb reset flags k%0d", k), 32'(o.flags), 32'd0);
      end
      scoreboardStep(1, k);
    end

    // Instance must accept ordinary work again after the abandoned multiply.
    @(negedge clock);
    applyStimulus(1, mkStim(4'hE, 4'b0000, 2'b00, 0, 1, 0, 0, 0));
    #1;
    checkOutput("post-reset reg_write", 32'(readOutputs(1).reg_write), 32'd1);
    @(negedge clock);
    applyStimulus(1, idleStim(4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
